request_scheduler: RTL and testbench

Consumes the one-cycle `key_press` pulses from the key input stage and turns them into latched floor requests for the elevator car controller. The block holds one pending bit per floor and runs a direction FSM (IDLE/UP/DOWN, SCAN-style). From the pending set and the car's current floor it outputs the next target floor. The car controller reports each stop with an `arrive` pulse, which clears the request at that floor.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/nearest_request.sv | 47 ++++
 rtl/request_scheduler.sv | 111 +++++++++++
 tb/tb_request_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: direction encoding and default floor geometry.
package elevator_pkg;

  localparam int unsigned W_DEFAULT  = 4;
  localparam int unsigned FW_DEFAULT = 2;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    StIdle = DIR_IDLE,
    StUp   = DIR_UP,
    StDown = DIR_DOWN
  } dir_e;

endpackage

// File: rtl/nearest_request.sv
// Locates pending requests relative to the car: above/below/here flags plus the
// nearest pending floor in each direction. Purely combinational.
module nearest_request #(
  parameter int unsigned W  = elevator_pkg::W_DEFAULT,
  parameter int unsigned FW = elevator_pkg::FW_DEFAULT
) (
  input  logic [W-1:0]  pending_i,
  input  logic [FW-1:0] cur_floor_i,
  output logic          above_o,
  output logic          below_o,
  output logic          here_o,
  output logic [FW-1:0] lowest_above_o,
  output logic [FW-1:0] highest_below_o
);

  int   cur_idx;
  logic floor_valid;

  assign cur_idx     = int'(cur_floor_i);
  assign floor_valid = (cur_idx < int'(W));

  always_comb begin
    above_o         = 1'b0;
    below_o         = 1'b0;
    here_o          = 1'b0;
    lowest_above_o  = '0;
    highest_below_o = '0;
    // Downward scan so the last hit is the lowest index above the car.
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (pending_i[i] && (!floor_valid || (i > cur_idx))) begin
        above_o        = 1'b1;
        lowest_above_o = FW'(i);
      end
    end
    // Upward scan so the last hit is the highest index below the car.
    for (int i = 0; i < int'(W); i++) begin
      if (pending_i[i] && floor_valid && (i < cur_idx)) begin
        below_o         = 1'b1;
        highest_below_o = FW'(i);
      end
      if (pending_i[i] && (i == cur_idx)) begin
        here_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_scheduler.sv
// Latches floor call pulses and runs a SCAN-style direction FSM that picks the
// next target floor for the car controller. All outputs are registered.
module request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned FW = FW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  key_press,
  input  logic [FW-1:0] cur_floor,
  input  logic          arrive,
  output logic [W-1:0]  pending,
  output logic [1:0]    dir,
  output logic [FW-1:0] target,
  output logic          target_valid
);

  logic [W-1:0]  pending_q, pending_d, clear_mask;
  dir_e          state_q, state_d;
  logic [FW-1:0] target_q, target_d;
  logic          valid_q, valid_d;

  logic          above, below, here;
  logic [FW-1:0] lowest_above, highest_below;

  nearest_request #(
    .W  (W),
    .FW (FW)
  ) u_nearest (
    .pending_i       (pending_q),
    .cur_floor_i     (cur_floor),
    .above_o         (above),
    .below_o         (below),
    .here_o          (here),
    .lowest_above_o  (lowest_above),
    .highest_below_o (highest_below)
  );

  // An arrive at an out-of-range floor matches no bit and so clears nothing.
  always_comb begin
    clear_mask = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (arrive && (cur_floor == FW'(i))) begin
        clear_mask[i] = 1'b1;
      end
    end
  end

  assign pending_d = (pending_q | key_press) & ~clear_mask;

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StDown: begin
        if (below)      state_d = StDown;
        else if (above) state_d = StUp;
        else            state_d = StIdle;
      end
      StIdle, StUp: begin
        if (above)      state_d = StUp;
        else if (below) state_d = StDown;
        else            state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    target_d = '0;
    valid_d  = 1'b0;
    unique case (state_d)
      StUp: begin
        target_d = lowest_above;
        valid_d  = 1'b1;
      end
      StDown: begin
        target_d = highest_below;
        valid_d  = 1'b1;
      end
      default: begin
        // Idle with a call at the current floor means open the door here.
        if (here) begin
          target_d = cur_floor;
          valid_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      state_q   <= StIdle;
      target_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      target_q  <= target_d;
      valid_q   <= valid_d;
    end
  end

  assign pending      = pending_q;
  assign dir          = state_q;
  assign target       = target_q;
  assign target_valid = valid_q;

endmodule

// File: tb/tb_request_scheduler.sv
// Self-checking bench for request_scheduler: directed vector table, a short
// hand sequence, then random traffic against a queue-based reference model.
module tb_request_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] key_press;
  logic [1:0] cur_floor;
  logic       arrive;
  logic [3:0] pending;
  logic [1:0] dir;
  logic [1:0] target;
  logic       target_valid;

  int n_vec;
  int n_bad;

  // Reference model state
  logic [3:0] m_pend;
  logic [1:0] m_dir;
  logic [1:0] m_tgt;
  logic       m_val;

  request_scheduler #(
    .W  (4),
    .FW (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_press    (key_press),
    .cur_floor    (cur_floor),
    .arrive       (arrive),
    .pending      (pending),
    .dir          (dir),
    .target       (target),
    .target_valid (target_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] kp;
    logic [1:0] cf;
    logic       ar;
    logic [3:0] e_pend;
    logic [1:0] e_dir;
    logic [1:0] e_tgt;
    logic       e_val;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Scheduling decision from the rules: floors sorted into above/below lists.
  task automatic model_step(input logic r, input logic [3:0] kp, input logic [1:0] cf,
                            input logic ar);
    int   up_q[$];
    int   dn_q[$];
    logic [1:0] nd;
    if (r) begin
      m_pend = 4'b0000;
      m_dir  = 2'b00;
      m_tgt  = 2'd0;
      m_val  = 1'b0;
    end else begin
      for (int f = 0; f < 4; f++) begin
        if (m_pend[f]) begin
          if (f > int'(cf)) up_q.push_back(f);
          else if (f < int'(cf)) dn_q.push_back(f);
        end
      end
      if (m_dir == 2'b10 && dn_q.size() != 0) nd = 2'b10;
      else if (up_q.size() != 0)              nd = 2'b01;
      else if (dn_q.size() != 0)              nd = 2'b10;
      else                                    nd = 2'b00;
      m_dir = nd;
      if (nd == 2'b01) begin
        up_q.sort();
        m_tgt = 2'(up_q[0]);
        m_val = 1'b1;
      end else if (nd == 2'b10) begin
        dn_q.sort();
        m_tgt = 2'(dn_q[dn_q.size() - 1]);
        m_val = 1'b1;
      end else if (m_pend[cf]) begin
        m_tgt = cf;
        m_val = 1'b1;
      end else begin
        m_tgt = 2'd0;
        m_val = 1'b0;
      end
      m_pend = m_pend | kp;
      if (ar) m_pend[cf] = 1'b0;
    end
  endtask

  task automatic drive_cycle(input logic r, input logic [3:0] kp, input logic [1:0] cf,
                             input logic ar);
    rst       = r;
    key_press = kp;
    cur_floor = cf;
    arrive    = ar;
    @(posedge clk);
    #1;
    model_step(r, kp, cf, ar);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] e_pend,
                               input logic [1:0] e_dir, input logic [1:0] e_tgt,
                               input logic e_val);
    check({tag, ".pending"}, int'(pending), int'(e_pend));
    check({tag, ".dir"}, int'(dir), int'(e_dir));
    check({tag, ".target"}, int'(target), int'(e_tgt));
    check({tag, ".target_valid"}, int'(target_valid), int'(e_val));
  endtask

  vec_t vecs[$];

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    key_press = 4'b0000;
    cur_floor = 2'd0;
    arrive    = 1'b0;
    m_pend    = 4'b0000;
    m_dir     = 2'b00;
    m_tgt     = 2'd0;
    m_val     = 1'b0;

    //              r   kp       cf    ar    pend     dir    tgt   val
    vecs.push_back('{1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0010, 2'd0, 1'b0, 4'b0010, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 2'd0, 1'b0, 4'b0010, 2'b01, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 2'd1, 1'b1, 4'b0000, 2'b00, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 2'd1, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0001, 2'd2, 1'b0, 4'b0001, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 4'b0001, 2'b10, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 4'b0001, 2'b10, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b1000, 2'd2, 1'b0, 4'b1001, 2'b10, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 4'b1001, 2'b10, 2'd0, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 2'd1, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b1001, 2'd1, 1'b0, 4'b1001, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 2'd1, 1'b0, 4'b1001, 2'b01, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 2'd3, 1'b1, 4'b0001, 2'b10, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 2'd3, 1'b0, 4'b0001, 2'b10, 2'd0, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b1100, 2'd2, 1'b1, 4'b1000, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 4'b1000, 2'b01, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 2'd2, 1'b0, 4'b1111, 2'b01, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 4'b1111, 2'b01, 2'd3, 1'b1});
    vecs.push_back('{1'b1, 4'b0100, 2'd2, 1'b1, 4'b0000, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].r, vecs[i].kp, vecs[i].cf, vecs[i].ar);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_dir, vecs[i].e_tgt,
                    vecs[i].e_val);
    end

    // Idle door-open request yields to a newly appearing request elsewhere.
    drive_cycle(1'b1, 4'b0000, 2'd2, 1'b0);
    drive_cycle(1'b0, 4'b0100, 2'd2, 1'b0);
    check_outputs("here_only", 4'b0100, 2'b00, 2'd0, 1'b0);
    drive_cycle(1'b0, 4'b0001, 2'd2, 1'b0);
    check_outputs("here_open", 4'b0101, 2'b00, 2'd2, 1'b1);
    drive_cycle(1'b0, 4'b0000, 2'd2, 1'b0);
    check_outputs("dir_over_here", 4'b0101, 2'b10, 2'd0, 1'b1);
    // Car moves: cur_floor change reaches the outputs one edge later.
    drive_cycle(1'b0, 4'b0000, 2'd0, 1'b0);
    check_outputs("floor_move", 4'b0101, 2'b01, 2'd2, 1'b1);

    // Random traffic against the reference model.
    drive_cycle(1'b1, 4'b0000, 2'd0, 1'b0);
    for (int c = 0; c < 2000; c++) begin
      logic       r;
      logic [3:0] kp;
      logic [1:0] cf;
      logic       ar;
      r  = ($urandom_range(0, 63) == 0);
      kp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cf = 2'($urandom_range(0, 3));
      ar = ($urandom_range(0, 3) == 0);
      drive_cycle(r, kp, cf, ar);
      check_outputs($sformatf("rand%0d", c), m_pend, m_dir, m_tgt, m_val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
